// File: rtl/weight_rd_arbiter.sv
// Round-robin arbiter sharing one weight-memory read port among NO_LANES MAC lanes,
// with per-lane strided address generation and lane-tagged read-data return.
module weight_rd_arbiter #(
   parameter int NO_LANES = 4,
   parameter int ADDR_W   = 10,
   parameter int DATA_W   = 8,
   parameter int RD_LAT   = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic [ADDR_W-1:0]   base_addr,
   input  logic [ADDR_W-1:0]   start_offset,
   input  logic [ADDR_W-1:0]   stride,
   input  logic [10:0]         count,
   input  logic [NO_LANES-1:0] lane_req,
   output logic [NO_LANES-1:0] lane_gnt,
   output logic                mem_rd_en,
   output logic [ADDR_W-1:0]   mem_addr,
   input  logic [DATA_W-1:0]   mem_rd_data,
   output logic [DATA_W-1:0]   rd_data,
   output logic [NO_LANES-1:0] rd_valid,
   output logic                busy,
   output logic                done
);

   localparam int PTR_W = (NO_LANES > 1) ? $clog2(NO_LANES) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   state_t              state_q;
   logic [ADDR_W-1:0]   stride_q;
   logic [10:0]         count_q;
   logic [10:0]         cnt_q [NO_LANES];
   logic [ADDR_W-1:0]   acc_q [NO_LANES];
   logic [PTR_W-1:0]    rr_ptr_q;
   logic [NO_LANES-1:0] lane_gnt_q;
   logic                mem_rd_en_q;
   logic [ADDR_W-1:0]   mem_addr_q;
   logic [NO_LANES-1:0] pipe_q [RD_LAT];
   logic [NO_LANES-1:0] rd_valid_q;
   logic [DATA_W-1:0]   rd_data_q;
   logic                done_q;

   logic [NO_LANES-1:0] elig;
   logic                gnt_any_d;
   logic [PTR_W-1:0]    gnt_idx_d;
   logic [NO_LANES-1:0] gnt_oh_d;
   logic [ADDR_W-1:0]   gnt_addr_d;
   logic [PTR_W-1:0]    rr_ptr_d;
   logic                all_done_d;
   logic                in_flight;

   always_comb begin
      elig = '0;
      for (int i = 0; i < NO_LANES; i++) begin
         elig[i] = lane_req[i] && (cnt_q[i] < count_q);
      end

      // Cyclic search from rr_ptr: lanes at or above the pointer first, then the wrap-around.
      gnt_any_d = 1'b0;
      gnt_idx_d = '0;
      for (int i = 0; i < NO_LANES; i++) begin
         if (!gnt_any_d && elig[i] && (PTR_W'(i) >= rr_ptr_q)) begin
            gnt_any_d = 1'b1;
            gnt_idx_d = PTR_W'(i);
         end
      end
      for (int i = 0; i < NO_LANES; i++) begin
         if (!gnt_any_d && elig[i] && (PTR_W'(i) < rr_ptr_q)) begin
            gnt_any_d = 1'b1;
            gnt_idx_d = PTR_W'(i);
         end
      end

      gnt_oh_d   = '0;
      gnt_addr_d = '0;
      for (int i = 0; i < NO_LANES; i++) begin
         if (gnt_any_d && (gnt_idx_d == PTR_W'(i))) begin
            gnt_oh_d[i] = 1'b1;
            gnt_addr_d  = acc_q[i];
         end
      end

      rr_ptr_d = (gnt_idx_d == PTR_W'(NO_LANES - 1)) ? '0 : gnt_idx_d + PTR_W'(1);

      // Completion is judged on the counters as they will be after this cycle's grant.
      all_done_d = 1'b1;
      for (int i = 0; i < NO_LANES; i++) begin
         if ((cnt_q[i] + 11'(gnt_oh_d[i])) != count_q) all_done_d = 1'b0;
      end

      in_flight = |lane_gnt_q;
      for (int s = 0; s < RD_LAT; s++) begin
         in_flight = in_flight | (|pipe_q[s]);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         stride_q    <= '0;
         count_q     <= '0;
         rr_ptr_q    <= '0;
         lane_gnt_q  <= '0;
         mem_rd_en_q <= 1'b0;
         mem_addr_q  <= '0;
         rd_valid_q  <= '0;
         rd_data_q   <= '0;
         done_q      <= 1'b0;
         for (int i = 0; i < NO_LANES; i++) begin
            cnt_q[i] <= '0;
            acc_q[i] <= '0;
         end
         for (int s = 0; s < RD_LAT; s++) begin
            pipe_q[s] <= '0;
         end
      end else begin
         lane_gnt_q  <= '0;
         mem_rd_en_q <= 1'b0;
         done_q      <= 1'b0;

         // Return path: lane tag follows the issued read through RD_LAT stages.
         pipe_q[0] <= lane_gnt_q;
         for (int s = 1; s < RD_LAT; s++) begin
            pipe_q[s] <= pipe_q[s-1];
         end
         rd_valid_q <= pipe_q[RD_LAT-1];
         if (|pipe_q[RD_LAT-1]) rd_data_q <= mem_rd_data;

         case (state_q)
            IDLE: begin
               if (start) begin
                  stride_q <= stride;
                  count_q  <= count;
                  rr_ptr_q <= '0;
                  for (int i = 0; i < NO_LANES; i++) begin
                     cnt_q[i] <= '0;
                     acc_q[i] <= base_addr + start_offset + ADDR_W'(i);
                  end
                  state_q <= RUN;
               end
            end
            RUN: begin
               if (gnt_any_d) begin
                  lane_gnt_q  <= gnt_oh_d;
                  mem_rd_en_q <= 1'b1;
                  mem_addr_q  <= gnt_addr_d;
                  rr_ptr_q    <= rr_ptr_d;
               end
               for (int i = 0; i < NO_LANES; i++) begin
                  if (gnt_oh_d[i]) begin
                     cnt_q[i] <= cnt_q[i] + 11'd1;
                     acc_q[i] <= acc_q[i] + stride_q;
                  end
               end
               if (all_done_d) state_q <= DRAIN;
            end
            DRAIN: begin
               if (!in_flight) begin
                  done_q  <= 1'b1;
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign lane_gnt  = lane_gnt_q;
   assign mem_rd_en = mem_rd_en_q;
   assign mem_addr  = mem_addr_q;
   assign rd_data   = rd_data_q;
   assign rd_valid  = rd_valid_q;
   assign busy      = (state_q != IDLE);
   assign done      = done_q;

endmodule

// File: tb/tb_weight_rd_arbiter.sv
// Bench for weight_rd_arbiter: transaction-level reference model compared every cycle,
// plus directed scenarios with hand-computed grant orders, addresses and latencies.
module tb_weight_rd_arbiter;

   localparam int NL = 4;
   localparam int AW = 10;
   localparam int DW = 8;
   localparam int RL = 2;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          start = 1'b0;
   logic [AW-1:0] base_addr = '0;
   logic [AW-1:0] start_offset = '0;
   logic [AW-1:0] stride = '0;
   logic [10:0]   count = '0;
   logic [NL-1:0] lane_req = '0;
   logic [NL-1:0] lane_gnt;
   logic          mem_rd_en;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_rd_data = '0;
   logic [DW-1:0] rd_data;
   logic [NL-1:0] rd_valid;
   logic          busy;
   logic          done;

   always #5 clk = ~clk;

   weight_rd_arbiter #(.NO_LANES(NL), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(RL)) dut (
      .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
      .start_offset(start_offset), .stride(stride), .count(count),
      .lane_req(lane_req), .lane_gnt(lane_gnt), .mem_rd_en(mem_rd_en),
      .mem_addr(mem_addr), .mem_rd_data(mem_rd_data), .rd_data(rd_data),
      .rd_valid(rd_valid), .busy(busy), .done(done)
   );

   int n_chk = 0;
   int n_pass = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
   endtask

   function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
      return a[7:0] ^ 8'hA5;
   endfunction

   function automatic int oh2idx(input logic [NL-1:0] v);
      for (int i = 0; i < NL; i++) if (v[i]) return i;
      return -1;
   endfunction

   // Memory: data for a read issued in cycle C is presented throughout cycle C+RL.
   logic          hist_en   [RL+1] = '{default: 1'b0};
   logic [AW-1:0] hist_addr [RL+1] = '{default: '0};
   initial forever begin
      @(negedge clk);
      for (int k = RL; k > 0; k--) begin
         hist_en[k]   = hist_en[k-1];
         hist_addr[k] = hist_addr[k-1];
      end
      hist_en[0]   = mem_rd_en;
      hist_addr[0] = mem_addr;
      mem_rd_data  = hist_en[RL] ? mem_word(hist_addr[RL]) : 8'h3C;
   end

   // Reference model: per-lane word counts, address = start + lane + k*stride,
   // returns scheduled as (lane, due edge) entries in a queue.
   int            ecount = 0;
   int            m_state = 0;
   int            m_start = 0;
   int            m_stride = 0;
   int            m_count = 0;
   int            m_words [NL] = '{default: 0};
   int            m_rr = 0;
   int            q_lane[$];
   int            q_due[$];
   logic [NL-1:0] e_gnt = '0;
   logic          e_en = 1'b0;
   logic [AW-1:0] e_addr = '0;
   logic [NL-1:0] e_rdv = '0;
   logic [DW-1:0] e_rdd = '0;
   logic          e_done = 1'b0;
   logic          e_busy = 1'b0;

   initial forever begin
      int g;
      int l;
      int fin;
      bit drained;
      @(posedge clk or negedge rst);
      if (!rst) begin
         m_state = 0;
         m_rr    = 0;
         foreach (m_words[i]) m_words[i] = 0;
         q_lane.delete();
         q_due.delete();
         e_gnt = '0; e_en = 1'b0; e_addr = '0; e_rdv = '0;
         e_rdd = '0; e_done = 1'b0; e_busy = 1'b0;
      end else begin
         ecount++;
         drained = (q_lane.size() == 0);
         e_gnt = '0; e_en = 1'b0; e_done = 1'b0; e_rdv = '0;
         if (q_due.size() > 0 && q_due[0] == ecount) begin
            e_rdv = NL'(1) << q_lane[0];
            e_rdd = mem_rd_data;
            void'(q_lane.pop_front());
            void'(q_due.pop_front());
         end
         case (m_state)
            0: if (start) begin
               m_start  = int'(base_addr) + int'(start_offset);
               m_stride = int'(stride);
               m_count  = int'(count);
               foreach (m_words[i]) m_words[i] = 0;
               m_rr     = 0;
               m_state  = 1;
            end
            1: begin
               g = -1;
               for (int k = 0; k < NL; k++) begin
                  l = (m_rr + k) % NL;
                  if (g < 0 && lane_req[l] && m_words[l] < m_count) g = l;
               end
               if (g >= 0) begin
                  e_gnt  = NL'(1) << g;
                  e_en   = 1'b1;
                  e_addr = AW'((m_start + g + m_words[g] * m_stride) % (1 << AW));
                  m_words[g]++;
                  m_rr = (g + 1) % NL;
                  q_lane.push_back(g);
                  q_due.push_back(ecount + RL + 1);
               end
               fin = 1;
               foreach (m_words[i]) if (m_words[i] != m_count) fin = 0;
               if (fin != 0) m_state = 2;
            end
            2: if (drained) begin
               e_done  = 1'b1;
               m_state = 0;
            end
            default: m_state = 0;
         endcase
         e_busy = (m_state != 0);
      end
   end

   // Per-cycle comparison against the model, plus event logs for directed checks.
   bit            cmp_en = 1'b0;
   int            log_lane[$];
   int            log_addr[$];
   int            log_cyc[$];
   int            rdv_cyc[$];
   int            rdv_val[$];
   int            rdd_log[$];
   int            done_cyc[$];
   int            busy_cycles = 0;

   initial forever begin
      @(negedge clk);
      if (cmp_en) begin
         chk("lane_gnt", 32'(lane_gnt), 32'(e_gnt));
         chk("mem_rd_en", 32'(mem_rd_en), 32'(e_en));
         chk("mem_addr", 32'(mem_addr), 32'(e_addr));
         chk("rd_valid", 32'(rd_valid), 32'(e_rdv));
         if (e_rdv != '0) chk("rd_data", 32'(rd_data), 32'(e_rdd));
         chk("busy", 32'(busy), 32'(e_busy));
         chk("done", 32'(done), 32'(e_done));
         if (mem_rd_en) begin
            log_lane.push_back(oh2idx(lane_gnt));
            log_addr.push_back(int'(mem_addr));
            log_cyc.push_back(ecount);
         end
         if (rd_valid != '0) begin
            rdv_cyc.push_back(ecount);
            rdv_val.push_back(int'(rd_valid));
            rdd_log.push_back(int'(rd_data));
         end
         if (done) done_cyc.push_back(ecount);
         if (busy) busy_cycles++;
      end
   end

   task automatic clear_logs();
      log_lane.delete(); log_addr.delete(); log_cyc.delete();
      rdv_cyc.delete(); rdv_val.delete(); rdd_log.delete(); done_cyc.delete();
      busy_cycles = 0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_start(input int b, input int o, input int s, input int c);
      @(negedge clk);
      clear_logs();
      base_addr    = AW'(b);
      start_offset = AW'(o);
      stride       = AW'(s);
      count        = 11'(c);
      start        = 1'b1;
      @(negedge clk);
      start        = 1'b0;
      base_addr    = AW'($urandom);
      start_offset = AW'($urandom);
      stride       = AW'($urandom);
      count        = 11'($urandom);
   endtask

   task automatic wait_done(input string name, input int budget);
      int n;
      n = 0;
      while (n < budget) begin
         @(negedge clk);
         if (done === 1'b1) break;
         n++;
      end
      chk(name, 32'(n < budget), 32'd1);
   endtask

   int t1_addr [8]  = '{104, 105, 106, 107, 132, 133, 134, 135};
   int t1_lane [8]  = '{0, 1, 2, 3, 0, 1, 2, 3};
   int t2_lane [12] = '{0, 2, 0, 2, 0, 2, 3, 1, 3, 1, 3, 1};
   int t2_addr [12] = '{0, 2, 16, 18, 32, 34, 3, 1, 19, 17, 35, 33};

   initial begin
      rst = 1'b0;
      @(posedge clk);
      #1 cmp_en = 1'b1;
      repeat (2) @(posedge clk);
      #1 chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_gnt", 32'(lane_gnt), 32'd0);
      @(posedge clk);
      #2 rst = 1'b1;

      // Full pass, all lanes requesting.
      lane_req = 4'b1111;
      do_start(100, 4, 28, 2);
      wait_done("t1_done_seen", 60);
      idle(3);
      chk("t1_ngrants", 32'(log_lane.size()), 32'd8);
      for (int i = 0; i < 8; i++) begin
         if (i < log_lane.size()) begin
            chk("t1_lane", 32'(log_lane[i]), 32'(t1_lane[i]));
            chk("t1_addr", 32'(log_addr[i]), 32'(t1_addr[i]));
         end
      end
      if (log_cyc.size() == 8) chk("t1_consecutive", 32'(log_cyc[7] - log_cyc[0]), 32'd7);
      chk("t1_nrdv", 32'(rdv_cyc.size()), 32'd8);
      chk("t1_ndone", 32'(done_cyc.size()), 32'd1);
      if (done_cyc.size() > 0 && rdv_cyc.size() > 0)
         chk("t1_done_after_rdv", 32'(done_cyc[0] - rdv_cyc[rdv_cyc.size()-1]), 32'd1);

      // Two lanes requesting; pass stays open until the others join.
      lane_req = 4'b0101;
      do_start(0, 0, 16, 3);
      idle(15);
      chk("t2_busy_hold", 32'(busy), 32'd1);
      chk("t2_ngrants_a", 32'(log_lane.size()), 32'd6);
      lane_req = 4'b1111;
      wait_done("t2_done_seen", 60);
      idle(3);
      chk("t2_ngrants", 32'(log_lane.size()), 32'd12);
      for (int i = 0; i < 12; i++) begin
         if (i < log_lane.size()) begin
            chk("t2_lane", 32'(log_lane[i]), 32'(t2_lane[i]));
            chk("t2_addr", 32'(log_addr[i]), 32'(t2_addr[i]));
         end
      end

      // count = 0: no reads, two busy cycles, then done.
      lane_req = 4'b1111;
      do_start(0, 0, 1, 0);
      wait_done("t3_done_seen", 20);
      idle(3);
      chk("t3_nreads", 32'(log_lane.size()), 32'd0);
      chk("t3_busy_cycles", 32'(busy_cycles), 32'd2);
      chk("t3_ndone", 32'(done_cyc.size()), 32'd1);
      chk("t3_idle", 32'(busy), 32'd0);

      // Address wrap at 2^ADDR_W.
      lane_req = 4'b0001;
      do_start(1020, 0, 4, 2);
      idle(8);
      chk("t4_n", 32'(log_addr.size()), 32'd2);
      if (log_addr.size() >= 2) begin
         chk("t4_addr0", 32'(log_addr[0]), 32'd1020);
         chk("t4_addr1", 32'(log_addr[1]), 32'd0);
      end
      lane_req = 4'b1111;
      wait_done("t4_done_seen", 60);
      idle(3);
      chk("t4_total", 32'(log_lane.size()), 32'd8);

      // Single grant: read-return latency and data capture.
      lane_req = 4'b0000;
      do_start(200, 0, 1, 1);
      idle(2);
      lane_req = 4'b0100;
      @(negedge clk);
      lane_req = 4'b0000;
      idle(8);
      chk("t5_n", 32'(log_lane.size()), 32'd1);
      if (log_lane.size() == 1 && rdv_cyc.size() == 1) begin
         chk("t5_lane", 32'(log_lane[0]), 32'd2);
         chk("t5_addr", 32'(log_addr[0]), 32'd202);
         chk("t5_latency", 32'(rdv_cyc[0] - log_cyc[0]), 32'd3);
         chk("t5_rdv", 32'(rdv_val[0]), 32'b0100);
         chk("t5_rdata", 32'(rdd_log[0]), 32'h6F);
      end else begin
         chk("t5_nrdv", 32'(rdv_cyc.size()), 32'd1);
      end
      lane_req = 4'b1111;
      wait_done("t5_done_seen", 60);
      idle(3);

      // start while running is ignored.
      lane_req = 4'b1111;
      do_start(8, 0, 2, 1);
      base_addr = AW'(500);
      count     = 11'd5;
      start     = 1'b1;
      @(negedge clk);
      start     = 1'b0;
      wait_done("t6_done_seen", 60);
      idle(12);
      chk("t6_ngrants", 32'(log_lane.size()), 32'd4);
      chk("t6_ndone", 32'(done_cyc.size()), 32'd1);
      chk("t6_idle", 32'(busy), 32'd0);

      // Asynchronous reset with reads in flight.
      lane_req = 4'b1111;
      do_start(40, 0, 4, 5);
      idle(5);
      @(posedge clk);
      #2 rst = 1'b0;
      #1;
      chk("t7_gnt", 32'(lane_gnt), 32'd0);
      chk("t7_en", 32'(mem_rd_en), 32'd0);
      chk("t7_addr", 32'(mem_addr), 32'd0);
      chk("t7_rdata", 32'(rd_data), 32'd0);
      chk("t7_rdv", 32'(rd_valid), 32'd0);
      chk("t7_busy", 32'(busy), 32'd0);
      chk("t7_done", 32'(done), 32'd0);
      repeat (2) @(posedge clk);
      #2 rst = 1'b1;
      clear_logs();
      idle(15);
      chk("t7_no_rdv", 32'(rdv_cyc.size()), 32'd0);
      chk("t7_no_done", 32'(done_cyc.size()), 32'd0);
      chk("t7_no_reads", 32'(log_lane.size()), 32'd0);
      chk("t7_idle", 32'(busy), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
